// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one memory port between I/D cache block fills and D-cache write-throughs
module cache_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    input  logic              mem_data_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic              d_wr_ack,
    output logic              err
);

    localparam int BW = $clog2(BEATS) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] beat;
    logic [TW-1:0] timer;
    logic          rr_last;     // 0 = I-cache finished the last fill, 1 = D-cache
    logic          err_q;

    logic filling;
    logic fill_done;
    logic fill_timeout;

    assign filling      = (state == FILL_I) || (state == FILL_D);
    assign fill_done    = filling && mem_data_valid && (beat == BEAT_LAST);
    assign fill_timeout = filling && !mem_data_valid && (timer == TIMER_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timer counts silent cycles since the last beat; abort fires as it would reach TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat    <= '0;
            timer   <= '0;
            rr_last <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (!filling || fill_done || fill_timeout) begin
                beat  <= '0;
                timer <= '0;
            end else if (mem_data_valid) begin
                beat  <= beat + 1'b1;
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (fill_done) begin
                rr_last <= (state == FILL_D);
            end
            if (fill_timeout || (mem_data_valid && !filling)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_wr_req) begin
                    state_nxt = WRITE;
                end else if (i_req && d_req) begin
                    state_nxt = rr_last ? FILL_I : FILL_D;
                end else if (i_req) begin
                    state_nxt = FILL_I;
                end else if (d_req) begin
                    state_nxt = FILL_D;
                end
            end
            FILL_I, FILL_D: begin
                if (fill_done || fill_timeout) begin
                    state_nxt = IDLE;
                end
            end
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        d_wr_ack     = 1'b0;
        err          = err_q;
        case (state)
            FILL_I: begin
                mem_enable   = 1'b1;
                mem_addr     = i_addr;
                i_grant      = 1'b1;
                i_data_valid = mem_data_valid;
            end
            FILL_D: begin
                mem_enable   = 1'b1;
                mem_addr     = d_addr;
                d_grant      = 1'b1;
                d_data_valid = mem_data_valid;
            end
            WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_wr_addr;
                mem_wdata  = d_wr_data;
                d_wr_ack   = 1'b1;
            end
            default: begin
                mem_enable = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int K_I = 0;
    localparam int K_D = 1;
    localparam int K_W = 2;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic        mem_data_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_enable;
    logic        mem_wr;
    logic        i_grant;
    logic        d_grant;
    logic        i_data_valid;
    logic        d_data_valid;
    logic        d_wr_ack;
    logic        err;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BEATS(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_data_valid(mem_data_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .d_wr_ack(d_wr_ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every routed beat or store ack must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("onehot_grant", 32'($countones({i_grant, d_grant, d_wr_ack}) <= 1), 32'd1);
            if (i_data_valid || d_data_valid || d_wr_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {29'd0, i_data_valid, d_data_valid, d_wr_ack}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (i_data_valid) begin
                        chk("i_beat_kind", K_I, e.kind);
                        chk("i_beat_addr", 32'(mem_addr), 32'(e.addr));
                    end else if (d_data_valid) begin
                        chk("d_beat_kind", K_D, e.kind);
                        chk("d_beat_addr", 32'(mem_addr), 32'(e.addr));
                    end else begin
                        chk("wr_kind", K_W, e.kind);
                        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                        chk("wr_data", 32'(mem_wdata), 32'(e.data));
                        chk("wr_mem_wr", 32'(mem_wr), 32'd1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0; mem_data_valid = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // n beats for cache `kind`, gap cycles between beat starts; returns just after the last beat's edge.
    task automatic beats(int kind, int n, int gap);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (k > 0) repeat (gap - 1) tick();
            e.kind = kind;
            e.addr = (kind == K_I) ? i_addr : d_addr;
            e.data = 16'h0;
            exp_q.push_back(e);
            mem_data_valid = 1'b1;
            tick();
            mem_data_valid = 1'b0;
            if (kind == K_I) i_addr = i_addr + 16'd2;
            else             d_addr = d_addr + 16'd2;
        end
    endtask

    initial begin
        exp_t w;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0; mem_data_valid = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;

        // Reset state
        @(negedge clk);
        chk("rst_outputs", {mem_enable, mem_wr, i_grant, d_grant, i_data_valid, d_data_valid, d_wr_ack, err}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        do_reset();

        // Single I miss, valids 4 cycles apart
        i_req = 1'b1; i_addr = 16'h0040;
        @(negedge clk);
        chk("i_grant_not_yet", 32'(i_grant), 32'd0);
        tick();
        @(negedge clk);
        chk("i_grant_next", 32'(i_grant), 32'd1);
        chk("i_fill_addr", 32'(mem_addr), 32'h0040);
        chk("i_fill_en_rd", {mem_enable, mem_wr}, 32'b10);
        beats(K_I, 8, 4);
        i_req = 1'b0;
        @(negedge clk);
        chk("i_grant_drop", 32'(i_grant), 32'd0);
        chk("idle_enable", 32'(mem_enable), 32'd0);

        // Simultaneous requests from reset: D first, then I, with a store during FILL_I
        do_reset();
        i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0300; d_addr = 16'h0100;
        tick();
        @(negedge clk);
        chk("both_d_first", {i_grant, d_grant}, 32'b01);
        chk("d_fill_addr", 32'(mem_addr), 32'h0100);
        beats(K_D, 8, 1);
        d_req = 1'b0;
        @(negedge clk);
        chk("d_drop", {i_grant, d_grant}, 32'b00);
        tick();
        @(negedge clk);
        chk("i_after_d", {i_grant, d_grant}, 32'b10);
        beats(K_I, 3, 2);
        d_wr_req = 1'b1; d_wr_addr = 16'h1234; d_wr_data = 16'hBEEF;
        beats(K_I, 5, 2);
        i_req = 1'b0;
        w.kind = K_W; w.addr = 16'h1234; w.data = 16'hBEEF;
        exp_q.push_back(w);
        @(negedge clk);
        chk("no_ack_in_idle", {i_grant, d_wr_ack}, 32'd0);
        tick();
        @(negedge clk);
        chk("store_ack", 32'(d_wr_ack), 32'd1);
        tick();
        d_wr_req = 1'b0;
        @(negedge clk);
        chk("store_one_cycle", {d_wr_ack, mem_enable}, 32'd0);
        chk("no_err_so_far", 32'(err), 32'd0);

        // Timeout after two D beats
        do_reset();
        d_req = 1'b1; d_addr = 16'h0200;
        tick();
        beats(K_D, 2, 1);
        d_req = 1'b0;
        repeat (63) tick();
        @(negedge clk);
        chk("pre_timeout", {err, d_grant}, 32'b01);
        tick();
        @(negedge clk);
        chk("timeout", {err, d_grant, mem_enable}, 32'b100);

        // Spurious valid in IDLE
        do_reset();
        mem_data_valid = 1'b1;
        @(negedge clk);
        chk("spur_routing", {i_data_valid, d_data_valid, err}, 32'd0);
        tick();
        mem_data_valid = 1'b0;
        @(negedge clk);
        chk("spur_err", {err, mem_enable, i_grant, d_grant}, 32'b1000);

        // Reset mid-fill clears rr_last back to I
        do_reset();
        d_req = 1'b1; d_addr = 16'h0400;
        tick();
        beats(K_D, 8, 1);
        tick();
        beats(K_D, 5, 1);
        @(negedge clk);
        chk("mid_fill_grant", 32'(d_grant), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_outputs", {mem_enable, mem_wr, i_grant, d_grant, d_wr_ack, err}, 32'd0);
        chk("async_rst_addr", 32'(mem_addr), 32'd0);
        exp_q.delete();
        d_req = 1'b0;
        tick();
        rst = 1'b1;
        i_req = 1'b1; d_req = 1'b1;
        tick();
        @(negedge clk);
        chk("rr_reset_to_i", {i_grant, d_grant}, 32'b01);
        do_reset();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
